// File: rtl/branch_resolver.sv
// branch_resolver: two-stage pipelined branch condition evaluator with
// valid/ready handshakes, flush, and saturating statistics counters.
// Optional build macro: BRANCH_SIGNED_CMP_EN -- when defined, the ordering
// conditions (BLT/BGT/BLE/BGE) compare the operands as two's-complement signed
// values; otherwise every comparison is unsigned. Equality is unaffected.
module branch_resolver #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           ctrl,
  input  logic [WIDTH-1:0]     R15,
  input  logic [WIDTH-1:0]     readData1,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 taken,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  localparam logic [2:0] CC_NONE = 3'd0;
  localparam logic [2:0] CC_BLT  = 3'd1;
  localparam logic [2:0] CC_BGT  = 3'd2;
  localparam logic [2:0] CC_BEQ  = 3'd3;
  localparam logic [2:0] CC_BNE  = 3'd4;
  localparam logic [2:0] CC_BLE  = 3'd5;
  localparam logic [2:0] CC_BGE  = 3'd6;
  localparam logic [2:0] CC_RSVD = 3'd7;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Stage 1: captured request
  logic             r_s1_valid;
  logic [2:0]       r_s1_ctrl;
  logic [WIDTH-1:0] r_s1_ref;
  logic [WIDTH-1:0] r_s1_tst;

  // Stage 2: resolved decision
  logic             r_s2_valid;
  logic [2:0]       r_s2_ctrl;
  logic             r_s2_taken;

  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_taken_cnt;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_accept;
  logic w_consume;
  logic w_eq;
  logic w_lt;
  logic w_gt;
  logic w_cond;
  logic w_is_branch;

  // Handshake and stage-advance conditions
  always_comb begin
    w_s2_adv    = !r_s2_valid || out_ready;
    w_s1_adv    = !r_s1_valid || w_s2_adv;
    in_ready    = w_s1_adv && !flush && !rst;
    w_accept    = in_valid && in_ready;
    w_consume   = r_s2_valid && out_ready;
    w_is_branch = (r_s2_ctrl != CC_NONE) && (r_s2_ctrl != CC_RSVD);
  end

  // Operand comparison on the stage-1 contents (readData1 against R15)
  always_comb begin
    w_eq = (r_s1_tst == r_s1_ref);
`ifdef BRANCH_SIGNED_CMP_EN
    w_lt = ($signed(r_s1_tst) < $signed(r_s1_ref));
`else
    w_lt = (r_s1_tst < r_s1_ref);
`endif
    w_gt = !w_lt && !w_eq;
  end

  // Condition-code decode; none and reserved codes never take
  always_comb begin
    w_cond = 1'b0;
    case (r_s1_ctrl)
      CC_BLT:  w_cond = w_lt;
      CC_BGT:  w_cond = w_gt;
      CC_BEQ:  w_cond = w_eq;
      CC_BNE:  w_cond = !w_eq;
      CC_BLE:  w_cond = w_lt || w_eq;
      CC_BGE:  w_cond = w_gt || w_eq;
      default: w_cond = 1'b0;
    endcase
  end

  // Pipeline registers; reset beats flush, flush beats the handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= CC_NONE;
      r_s1_ref   <= '0;
      r_s1_tst   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_ctrl  <= CC_NONE;
      r_s2_taken <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_taken <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        r_s2_ctrl  <= r_s1_ctrl;
        r_s2_taken <= r_s1_valid && w_cond;
      end
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_ctrl <= ctrl;
          r_s1_ref  <= R15;
          r_s1_tst  <= readData1;
        end
      end
    end
  end

  // Saturating statistics; a clear overrides a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (w_consume) begin
      if (w_is_branch && (r_branch_cnt != CNT_MAX)) begin
        r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
      end
      if (r_s2_taken && (r_taken_cnt != CNT_MAX)) begin
        r_taken_cnt <= r_taken_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign taken      = r_s2_taken;
  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (WIDTH=16, CNT_WIDTH=4).
module tb_branch_resolver;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           ctrl;
  logic [WIDTH-1:0]     R15;
  logic [WIDTH-1:0]     readData1;
  logic                 flush;
  logic                 cnt_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic                 taken;
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] taken_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolver #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ctrl       (ctrl),
    .R15        (R15),
    .readData1  (readData1),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taken      (taken),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  // Directed condition vectors: ctrl, R15, readData1, expected taken
  logic [2:0]       v_ctrl [8] = '{3'd2, 3'd1, 3'd5, 3'd6, 3'd0, 3'd7, 3'd4, 3'd6};
  logic [WIDTH-1:0] v_ref  [8] = '{16'h0001, 16'h0001, 16'h0007, 16'h0007,
                                   16'h0000, 16'h0005, 16'hFFFF, 16'hFFFF};
  logic [WIDTH-1:0] v_tst  [8] = '{16'h8000, 16'h8000, 16'h0007, 16'h0006,
                                   16'h0000, 16'h0005, 16'hFFFF, 16'h0000};
`ifdef BRANCH_SIGNED_CMP_EN
  logic             v_exp  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
  logic             v_exp  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [WIDTH-1:0] r,
                       input logic [WIDTH-1:0] t);
    in_valid  = v;
    ctrl      = c;
    R15       = r;
    readData1 = t;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
  endtask

  initial begin
    int exp_br;
    int exp_tk;
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
    drive(1'b1, 3'd3, 16'h0, 16'h0);
    #1;
    check_eq("in_ready_in_reset", 64'(in_ready), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_taken", 64'(taken), 64'd0);
    check_eq("rst_branch_cnt", 64'(branch_cnt), 64'd0);
    check_eq("rst_taken_cnt", 64'(taken_cnt), 64'd0);
    check_eq("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single BLT, taken
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 16'h1234, 16'h1233);
    cyc();
    in_valid = 1'b0;
    check_eq("blt_not_yet_valid", 64'(out_valid), 64'd0);
    cyc();
    check_eq("blt_out_valid", 64'(out_valid), 64'd1);
    check_eq("blt_taken", 64'(taken), 64'd1);
    cyc();
    check_eq("blt_drained", 64'(out_valid), 64'd0);
    check_eq("blt_taken_idle", 64'(taken), 64'd0);
    check_eq("blt_branch_cnt", 64'(branch_cnt), 64'd1);
    check_eq("blt_taken_cnt", 64'(taken_cnt), 64'd1);
    clear_counters();
    check_eq("clr_branch_cnt", 64'(branch_cnt), 64'd0);

    // Back-to-back BEQ
    drive(1'b1, 3'd3, 16'h1234, 16'h1234);
    cyc();
    drive(1'b1, 3'd3, 16'h1234, 16'h1233);
    cyc();
    in_valid = 1'b0;
    check_eq("beq1_valid", 64'(out_valid), 64'd1);
    check_eq("beq1_taken", 64'(taken), 64'd1);
    cyc();
    check_eq("beq2_valid", 64'(out_valid), 64'd1);
    check_eq("beq2_taken", 64'(taken), 64'd0);
    cyc();
    check_eq("beq_branch_cnt", 64'(branch_cnt), 64'd2);
    check_eq("beq_taken_cnt", 64'(taken_cnt), 64'd1);
    clear_counters();

    // Backpressure: two held, third refused until release
    out_ready = 1'b0;
    drive(1'b1, 3'd4, 16'h0001, 16'h0002);
    cyc();
    drive(1'b1, 3'd4, 16'h0005, 16'h0005);
    #1;
    check_eq("bp_ready_second", 64'(in_ready), 64'd1);
    cyc();
    drive(1'b1, 3'd1, 16'h0009, 16'h0003);
    #1;
    check_eq("bp_ready_full", 64'(in_ready), 64'd0);
    check_eq("bp_a_taken", 64'(taken), 64'd1);
    cyc();
    check_eq("bp_hold_valid", 64'(out_valid), 64'd1);
    check_eq("bp_hold_taken", 64'(taken), 64'd1);
    check_eq("bp_hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    check_eq("bp_b_valid", 64'(out_valid), 64'd1);
    check_eq("bp_b_taken", 64'(taken), 64'd0);
    cyc();
    check_eq("bp_c_valid", 64'(out_valid), 64'd1);
    check_eq("bp_c_taken", 64'(taken), 64'd1);
    cyc();
    check_eq("bp_drained", 64'(out_valid), 64'd0);
    check_eq("bp_branch_cnt", 64'(branch_cnt), 64'd3);
    check_eq("bp_taken_cnt", 64'(taken_cnt), 64'd2);
    clear_counters();

    // Condition table streamed at full rate
    exp_br = 0;
    exp_tk = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v_ctrl[i], v_ref[i], v_tst[i]);
      if (v_ctrl[i] != 3'd0 && v_ctrl[i] != 3'd7) exp_br++;
      if (v_exp[i]) exp_tk++;
      cyc();
      if (i > 0) begin
        check_eq($sformatf("vec%0d_valid", i - 1), 64'(out_valid), 64'd1);
        check_eq($sformatf("vec%0d_taken", i - 1), 64'(taken), 64'(v_exp[i - 1]));
      end
    end
    in_valid = 1'b0;
    cyc();
    check_eq("vec7_taken", 64'(taken), 64'(v_exp[7]));
    cyc();
    check_eq("vec_branch_cnt", 64'(branch_cnt), 64'(exp_br));
    check_eq("vec_taken_cnt", 64'(taken_cnt), 64'(exp_tk));
    clear_counters();

    // Flush with both stages full under backpressure
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 16'h0042, 16'h0042);
    cyc();
    cyc();
    check_eq("fl_full_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    #1;
    check_eq("fl_in_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_out_valid", 64'(out_valid), 64'd0);
    check_eq("fl_taken", 64'(taken), 64'd0);
    check_eq("fl_branch_cnt", 64'(branch_cnt), 64'd0);
    check_eq("fl_taken_cnt", 64'(taken_cnt), 64'd0);
    out_ready = 1'b1;
    cyc();
    cyc();
    check_eq("fl_nothing_left", 64'(out_valid), 64'd0);

    // Result consumed in the flush cycle is still counted
    drive(1'b1, 3'd3, 16'h0042, 16'h0042);
    cyc();
    cyc();
    in_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("flc_out_valid", 64'(out_valid), 64'd0);
    check_eq("flc_branch_cnt", 64'(branch_cnt), 64'd1);
    check_eq("flc_taken_cnt", 64'(taken_cnt), 64'd1);
    cyc();
    check_eq("flc_dropped", 64'(out_valid), 64'd0);
    clear_counters();

    // Saturation with 20 taken BEQ results
    drive(1'b1, 3'd3, 16'h00AA, 16'h00AA);
    for (int i = 0; i < 20; i++) cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    check_eq("sat_taken_cnt", 64'(taken_cnt), 64'd15);
    check_eq("sat_branch_cnt", 64'(branch_cnt), 64'd15);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    check_eq("clr_pending_valid", 64'(out_valid), 64'd1);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    check_eq("clr_wins_taken", 64'(taken_cnt), 64'd0);
    check_eq("clr_wins_branch", 64'(branch_cnt), 64'd0);
    check_eq("clr_consumed", 64'(out_valid), 64'd0);

    // Reset mid-operation discards in-flight requests
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 16'h0001, 16'h0001);
    cyc();
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("mrst_in_ready", 64'(in_ready), 64'd0);
    cyc();
    rst = 1'b0;
    check_eq("mrst_out_valid", 64'(out_valid), 64'd0);
    cyc();
    cyc();
    check_eq("mrst_empty", 64'(out_valid), 64'd0);
    check_eq("mrst_branch_cnt", 64'(branch_cnt), 64'd0);
    check_eq("mrst_taken_cnt", 64'(taken_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
